int_ack_seq: RTL and testbench

CPU-side interrupt acknowledge sequencer for the ACW processor model. It synchronises the controller's active-low interrupt request and accepts it at an instruction boundary. It then runs the two-pulse INTA bus sequence, captures the vector byte the controller drives on D, and holds an in-service flag until the handler's end-of-interrupt write, which it converts into the one-cycle ACK strobe that clears the pending source.

---
 rtl/int_pkg.sv | 26 ++
 rtl/sync_ff.sv | 25 ++
 rtl/int_ack_seq.sv | 148 ++++++++++++++
 tb/tb_int_ack_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the ACW interrupt acknowledge path.
package int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INTA1,
        ST_GAP1,
        ST_INTA2,
        ST_CAPT,
        ST_SERV
    } state_t;

    localparam logic [7:0] VEC_BASE  = 8'hD8;
    localparam logic [2:0] SPUR_CODE = 3'b111;

    localparam logic [7:0] VEC_VID = 8'hDE;
    localparam logic [7:0] VEC_AI0 = 8'hDD;
    localparam logic [7:0] VEC_AI1 = 8'hDC;
    localparam logic [7:0] VEC_AI2 = 8'hDB;

    // Spurious vectors carry SPUR_CODE in the low bits.
    function automatic logic is_spur(input logic [7:0] v);
        return v[2:0] == SPUR_CODE;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser with asynchronous active-high reset to RST_VAL.
module sync_ff #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sh;

    // Shift the asynchronous input through DEPTH flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh <= {DEPTH{RST_VAL}};
        end else begin
            sh <= {sh[DEPTH-2:0], d};
        end
    end

    assign q = sh[DEPTH-1];

endmodule

// File: rtl/int_ack_seq.sv
// Interrupt acknowledge sequencer: accept, two INTA pulses, vector capture,
// in-service tracking and end-of-interrupt acknowledge.
module int_ack_seq
    import int_pkg::*;
#(
    parameter int unsigned PW   = 2,
    parameter int unsigned GAP  = 2,
    parameter int unsigned SYNC = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       INTL,
    input  logic       IEN,
    input  logic       BOUND,
    input  logic       BUSY,
    input  logic [7:0] D,
    input  logic       EOI,
    output logic       INTAL,
    output logic [7:0] VEC,
    output logic       VECV,
    output logic       TAKEN,
    output logic       SPUR,
    output logic       INSVC,
    output logic       ACK
);

    localparam int unsigned MAXW = (PW > GAP) ? PW : GAP;
    localparam int unsigned CW   = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] PW_LD  = CW'(PW - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP - 1);

    logic          intl_s;
    logic          irq;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          cap;
    logic          ack_evt;

    sync_ff #(
        .DEPTH   (SYNC),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (CLK),
        .rst (RES),
        .d   (INTL),
        .q   (intl_s)
    );

    assign irq = ~intl_s;

    // State and shared pulse/gap counter registers.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter is reloaded on every state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        cap       = 1'b0;
        ack_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (irq && IEN && BOUND && !BUSY) begin
                    accept    = 1'b1;
                    state_nxt = ST_INTA1;
                    cnt_nxt   = PW_LD;
                end
            end
            ST_INTA1: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP1;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP1: begin
                if (cnt == '0) begin
                    state_nxt = ST_INTA2;
                    cnt_nxt   = PW_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_INTA2: begin
                if (cnt == '0) begin
                    state_nxt = ST_CAPT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_CAPT: begin
                // INTAL is registered one cycle behind the state, so this
                // cycle is the last low INTA cycle; D is captured here and
                // its code bits decide the branch (same as testing VEC).
                cap       = 1'b1;
                state_nxt = is_spur(D) ? ST_IDLE : ST_SERV;
            end
            ST_SERV: begin
                if (EOI) begin
                    ack_evt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered bus-facing outputs, vector capture and in-service flag.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            INTAL <= 1'b1;
            VEC   <= {VEC_BASE[7:3], SPUR_CODE};
            VECV  <= 1'b0;
            TAKEN <= 1'b0;
            SPUR  <= 1'b0;
            INSVC <= 1'b0;
            ACK   <= 1'b0;
        end else begin
            INTAL <= !(state == ST_INTA1 || state == ST_INTA2);
            VECV  <= cap;
            SPUR  <= cap && is_spur(D);
            TAKEN <= accept || (state inside {ST_INTA1, ST_GAP1, ST_INTA2, ST_CAPT});
            ACK   <= ack_evt;
            if (cap) begin
                VEC <= D;
            end
            if (cap && !is_spur(D)) begin
                INSVC <= 1'b1;
            end else if (ack_evt) begin
                INSVC <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_int_ack_seq.sv
// Bench for int_ack_seq: two parameterisations driven by shared stimulus,
// checked every cycle against a timeline model plus directed expectations.
module tb_int_ack_seq;

    logic       CLK = 1'b0;
    logic       RES, INTL, IEN, BOUND, BUSY, EOI;
    logic [7:0] D;
    logic [1:0] intal, vecv, taken, spur, insvc, ack;
    logic [7:0] vec0, vec1;

    always #5 CLK = ~CLK;

    int_ack_seq #(.PW(2), .GAP(2), .SYNC(2)) u_dut0 (
        .CLK(CLK), .RES(RES), .INTL(INTL), .IEN(IEN), .BOUND(BOUND),
        .BUSY(BUSY), .D(D), .EOI(EOI), .INTAL(intal[0]), .VEC(vec0),
        .VECV(vecv[0]), .TAKEN(taken[0]), .SPUR(spur[0]), .INSVC(insvc[0]),
        .ACK(ack[0])
    );

    int_ack_seq #(.PW(1), .GAP(3), .SYNC(3)) u_dut1 (
        .CLK(CLK), .RES(RES), .INTL(INTL), .IEN(IEN), .BOUND(BOUND),
        .BUSY(BUSY), .D(D), .EOI(EOI), .INTAL(intal[1]), .VEC(vec1),
        .VECV(vecv[1]), .TAKEN(taken[1]), .SPUR(spur[1]), .INSVC(insvc[1]),
        .ACK(ack[1])
    );

    int pw_p  [2] = '{2, 1};
    int gap_p [2] = '{2, 3};
    int syn_p [2] = '{2, 3};

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Model: k = cycles since acceptance (-1 = none), serv = handler running.
    int          k      [2] = '{-1, -1};
    bit          serv   [2];
    logic [15:0] hist   [2] = '{16'hFFFF, 16'hFFFF};
    logic [7:0]  m_vec  [2] = '{8'hDF, 8'hDF};
    bit          m_vecv [2];
    bit          m_spur [2];
    bit          m_ack  [2];

    // Observations of the DUTs for the directed checks.
    int taken_cyc [2];
    int vecv_cyc  [2];
    int low_cnt   [2];
    int vecv_cnt  [2];
    int spur_cnt  [2];
    int ack_cnt   [2];
    bit prev_taken[2];

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, idx, cyc, act, exp);
    endtask

    function automatic logic [7:0] vec_of(input int i);
        return (i == 0) ? vec0 : vec1;
    endfunction

    // Advance the model at each edge, then compare once outputs settle.
    always @(posedge CLK) begin
        int  t;
        bit  irq, acc, e_taken, e_intal;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            t = 2 * pw_p[i] + gap_p[i] + 1;
            if (RES) begin
                k[i] = -1; serv[i] = 0; hist[i] = 16'hFFFF; m_vec[i] = 8'hDF;
                m_vecv[i] = 0; m_spur[i] = 0; m_ack[i] = 0;
            end else begin
                irq = !hist[i][syn_p[i] - 1];
                acc = (k[i] < 0 || k[i] >= t) && !serv[i] && irq && IEN && BOUND && !BUSY;
                m_ack[i] = serv[i] && EOI;
                if (m_ack[i]) serv[i] = 0;
                hist[i] = {hist[i][14:0], INTL};
                if (acc) k[i] = 0;
                else if (k[i] >= 0 && k[i] <= t) k[i] = k[i] + 1;
                m_vecv[i] = (k[i] == t);
                m_spur[i] = 0;
                if (m_vecv[i]) begin
                    m_vec[i]  = D;
                    m_spur[i] = (D[2:0] == 3'b111);
                    serv[i]   = !m_spur[i];
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            t = 2 * pw_p[i] + gap_p[i] + 1;
            e_taken = (k[i] >= 0 && k[i] <= t);
            e_intal = !((k[i] >= 1 && k[i] <= pw_p[i]) ||
                        (k[i] >= pw_p[i] + gap_p[i] + 1 && k[i] <= 2 * pw_p[i] + gap_p[i]));
            check("INTAL", i, intal[i], e_intal);
            check("TAKEN", i, taken[i], e_taken);
            check("VECV",  i, vecv[i],  m_vecv[i]);
            check("SPUR",  i, spur[i],  m_spur[i]);
            check("INSVC", i, insvc[i], serv[i]);
            check("ACK",   i, ack[i],   m_ack[i]);
            check("VEC",   i, vec_of(i), m_vec[i]);
            if (!intal[i]) low_cnt[i]++;
            if (taken[i] && !prev_taken[i]) taken_cyc[i] = cyc;
            prev_taken[i] = taken[i];
            if (vecv[i]) begin vecv_cyc[i] = cyc; vecv_cnt[i]++; end
            if (spur[i]) spur_cnt[i]++;
            if (ack[i]) ack_cnt[i]++;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_bound();
        BOUND = 1'b1; tick(); BOUND = 1'b0; tick();
    endtask

    task automatic pulse_eoi();
        EOI = 1'b1; tick(); EOI = 1'b0;
    endtask

    task automatic wait_vecv(input int budget);
        int c0, c1, n;
        c0 = vecv_cnt[0]; c1 = vecv_cnt[1]; n = 0;
        while (!(vecv_cnt[0] > c0 && vecv_cnt[1] > c1) && n < budget) begin
            tick(); n++;
        end
        check("vecv_wait", 0, 8'(vecv_cnt[0] > c0 && vecv_cnt[1] > c1), 8'd1);
    endtask

    initial begin
        int fall, s0, s1, a0, a1, v0, v1, n;
        RES = 1'b1; INTL = 1'b1; IEN = 1'b0; BOUND = 1'b0; BUSY = 1'b0;
        D = 8'h00; EOI = 1'b0;
        repeat (3) tick();
        RES = 1'b0;
        check("rst_VEC", 0, vec0, 8'hDF);
        check("rst_VEC", 1, vec1, 8'hDF);
        check("rst_INTAL", 0, 8'(intal), 8'h03);

        // Main sequence with latency pins for both parameterisations.
        low_cnt = '{0, 0};
        fall = cyc; IEN = 1'b1; BOUND = 1'b1; D = 8'hDE; INTL = 1'b0;
        wait_vecv(30);
        BOUND = 1'b0;
        check("intl_to_accept", 0, 8'(taken_cyc[0] - fall), 8'd3);
        check("intl_to_accept", 1, 8'(taken_cyc[1] - fall), 8'd4);
        check("accept_to_vecv", 0, 8'(vecv_cyc[0] - taken_cyc[0]), 8'd7);
        check("accept_to_vecv", 1, 8'(vecv_cyc[1] - taken_cyc[1]), 8'd6);
        check("low_cycles", 0, 8'(low_cnt[0]), 8'd4);
        check("low_cycles", 1, 8'(low_cnt[1]), 8'd2);
        check("vec_DE", 0, vec0, 8'hDE);
        check("vec_DE", 1, vec1, 8'hDE);
        check("insvc_set", 0, 8'(insvc), 8'h03);

        // In service: BOUND pulses must not start another sequence.
        low_cnt = '{0, 0};
        repeat (4) pulse_bound();
        check("serv_block_low", 0, 8'(low_cnt[0] + low_cnt[1]), 8'd0);
        check("serv_block_taken", 0, 8'(taken), 8'h00);
        pulse_eoi();
        check("eoi_ack", 0, 8'(ack), 8'h03);
        check("eoi_insvc", 0, 8'(insvc), 8'h00);
        tick();
        check("ack_one_cycle", 0, 8'(ack), 8'h00);

        // Next BOUND accepts again and captures DB.
        D = 8'hDB; BOUND = 1'b1; tick(); BOUND = 1'b0;
        check("reaccept", 0, 8'(taken), 8'h03);
        wait_vecv(20);
        check("vec_DB", 0, vec0, 8'hDB);
        check("vec_DB", 1, vec1, 8'hDB);
        tick(); pulse_eoi(); tick();

        // IEN low, then BUSY high: no acceptance.
        low_cnt = '{0, 0};
        IEN = 1'b0;
        repeat (3) pulse_bound();
        IEN = 1'b1; BUSY = 1'b1;
        repeat (3) pulse_bound();
        check("gated_low", 0, 8'(low_cnt[0] + low_cnt[1]), 8'd0);
        check("gated_taken", 0, 8'(taken), 8'h00);
        BUSY = 1'b0; D = 8'hDD; BOUND = 1'b1; tick(); BOUND = 1'b0;
        check("ungated_accept", 0, 8'(taken), 8'h03);
        wait_vecv(20);
        check("vec_DD", 0, vec0, 8'hDD);
        tick(); pulse_eoi(); tick();

        // Request withdrawn after acceptance, controller returns spurious DF.
        s0 = spur_cnt[0]; s1 = spur_cnt[1];
        BOUND = 1'b1; tick(); BOUND = 1'b0; INTL = 1'b1; D = 8'hDF;
        wait_vecv(20);
        check("spur_seen", 0, 8'(spur_cnt[0] - s0), 8'd1);
        check("spur_seen", 1, 8'(spur_cnt[1] - s1), 8'd1);
        check("spur_insvc", 0, 8'(insvc), 8'h00);
        tick();
        a0 = ack_cnt[0]; a1 = ack_cnt[1];
        pulse_eoi(); tick();
        check("spur_no_ack", 0, 8'((ack_cnt[0] - a0) + (ack_cnt[1] - a1)), 8'd0);

        // Reset while INTAL is low in the first pulse.
        INTL = 1'b0; repeat (4) tick();
        BOUND = 1'b1; tick(); BOUND = 1'b0;
        n = 0;
        while (intal[0] !== 1'b0 && n < 5) begin tick(); n++; end
        check("inta1_reached", 0, 8'(intal[0]), 8'h00);
        #2 RES = 1'b1;
        #1;
        check("async_rst_INTAL", 0, 8'(intal), 8'h03);
        check("async_rst_TAKEN", 0, 8'(taken), 8'h00);
        tick(); RES = 1'b0;
        v0 = vecv_cnt[0]; v1 = vecv_cnt[1];
        repeat (15) tick();
        check("no_vecv_after_rst", 0, 8'((vecv_cnt[0] - v0) + (vecv_cnt[1] - v1)), 8'd0);

        // Randomised traffic, checked by the per-cycle model.
        repeat (2500) begin
            tick();
            if ($urandom_range(0, 15) == 0) INTL = ~INTL;
            IEN   = ($urandom_range(0, 9) != 0);
            BUSY  = ($urandom_range(0, 3) == 0);
            BOUND = ($urandom_range(0, 2) == 0);
            D     = {5'b11011, 3'($urandom)};
            EOI   = ($urandom_range(0, 7) == 0);
            RES   = ($urandom_range(0, 499) == 0);
        end
        tick(); RES = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
